// File: rtl/slot_pkg.sv
// Shared types for the slot reel block: reel symbols and controller states.
package slot_pkg;

  typedef enum logic [2:0] {
    BLANK     = 3'd0,
    LIME      = 3'd1,
    BANANA    = 3'd2,
    ORANGE    = 3'd3,
    BLUEBERRY = 3'd4,
    GRAPE     = 3'd5,
    CHERRY    = 3'd6,
    COCONUT   = 3'd7
  } symbol_t;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    STOPPING
  } state_t;

  localparam int GAP_W = 8;

endpackage

// File: rtl/reel_strip_lut.sv
// Reel strip: maps a 5-bit reel position to the symbol printed there.
module reel_strip_lut
  import slot_pkg::*;
(
  input  logic [4:0] i_pos,
  output symbol_t    o_sym
);

  // Even positions are the blank gaps between symbols.
  always_comb begin
    o_sym = BLANK;
    if (i_pos[0]) begin
      unique case (i_pos[4:1])
        4'd0:  o_sym = LIME;
        4'd1:  o_sym = BANANA;
        4'd2:  o_sym = ORANGE;
        4'd3:  o_sym = BLUEBERRY;
        4'd4:  o_sym = GRAPE;
        4'd5:  o_sym = LIME;
        4'd6:  o_sym = BANANA;
        4'd7:  o_sym = CHERRY;
        4'd8:  o_sym = ORANGE;
        4'd9:  o_sym = GRAPE;
        4'd10: o_sym = LIME;
        4'd11: o_sym = BLUEBERRY;
        4'd12: o_sym = BANANA;
        4'd13: o_sym = ORANGE;
        4'd14: o_sym = GRAPE;
        4'd15: o_sym = COCONUT;
      endcase
    end
  end

endmodule

// File: rtl/reel_spinner.sv
// Multi-reel spin controller with staggered, symbol-aligned stopping.
// Optional REEL_NUDGE_EN adds an IDLE-time nudge of a selected reel.
module reel_spinner
  import slot_pkg::*;
#(
  parameter int N_REELS  = 3,
  parameter int POS_W    = 5,
  parameter int STOP_GAP = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       stop,
`ifdef REEL_NUDGE_EN
  input  logic                       nudge,
  input  logic [((N_REELS > 1) ? $clog2(N_REELS) : 1)-1:0] nudge_sel,
`endif
  output logic [N_REELS*POS_W-1:0]   pos,
  output logic [N_REELS*3-1:0]       symbol,
  output logic [N_REELS-1:0]         spinning,
  output logic                       busy,
  output logic                       done
);

  localparam int SEL_W = (N_REELS > 1) ? $clog2(N_REELS) : 1;

  state_t                           r_state;
  logic [N_REELS-1:0][POS_W-1:0]    r_pos;
  logic [N_REELS-1:0]               r_spin;
  logic [N_REELS-1:0]               r_req;
  logic [GAP_W-1:0]                 r_gap;
  logic                             r_gap_on;
  logic [SEL_W-1:0]                 r_next;
  logic                             r_done;
  logic [N_REELS-1:0]               w_halt;

  // A requested reel only halts on an odd (symbol) position.
  always_comb begin
    w_halt = '0;
    for (int i = 0; i < N_REELS; i++) begin
      w_halt[i] = tick & r_spin[i] & r_req[i] & r_pos[i][0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      for (int i = 0; i < N_REELS; i++) begin
        r_pos[i] <= POS_W'(1);
      end
      r_spin   <= '0;
      r_req    <= '0;
      r_gap    <= '0;
      r_gap_on <= 1'b0;
      r_next   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SPIN;
            r_spin  <= '1;
          end
`ifdef REEL_NUDGE_EN
          if (nudge && (32'(nudge_sel) < N_REELS)) begin
            r_pos[nudge_sel] <= r_pos[nudge_sel] + POS_W'(2);
          end
`endif
        end
        SPIN: begin
          if (stop) begin
            r_state  <= STOPPING;
            r_req[0] <= 1'b1;
          end
        end
        STOPPING: begin
          if (tick && r_gap_on) begin
            if (r_gap == GAP_W'(STOP_GAP - 1)) begin
              r_gap_on      <= 1'b0;
              r_req[r_next] <= 1'b1;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          for (int i = 0; i < N_REELS; i++) begin
            if (w_halt[i]) begin
              r_spin[i] <= 1'b0;
              r_req[i]  <= 1'b0;
              if (i == N_REELS - 1) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_gap_on <= 1'b1;
                r_gap    <= '0;
                r_next   <= SEL_W'(i + 1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (tick && (r_state != IDLE)) begin
        for (int i = 0; i < N_REELS; i++) begin
          if (r_spin[i] && !w_halt[i]) begin
            r_pos[i] <= r_pos[i] + POS_W'(1);
          end
        end
      end
    end
  end

  assign pos      = r_pos;
  assign spinning = r_spin;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

  for (genvar g = 0; g < N_REELS; g++) begin : g_reel
    symbol_t w_sym;
    reel_strip_lut u_lut (
      .i_pos (r_pos[g][4:0]),
      .o_sym (w_sym)
    );
    assign symbol[g*3 +: 3] = w_sym;
  end

endmodule

// File: tb/tb_reel_spinner.sv
// Scoreboard bench for reel_spinner (3 reels, 5-bit positions, gap 8).
`timescale 1ns/1ps
module tb_reel_spinner;

  logic        clk = 1'b0;
  logic        rst, tick, start, stop;
  logic [14:0] pos;
  logic [8:0]  symbol;
  logic [2:0]  spinning;
  logic        busy, done;
`ifdef REEL_NUDGE_EN
  logic        nudge;
  logic [1:0]  nudge_sel;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  reel_spinner #(.N_REELS(3), .POS_W(5), .STOP_GAP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
`ifdef REEL_NUDGE_EN
    .nudge    (nudge),
    .nudge_sel(nudge_sel),
`endif
    .pos      (pos),
    .symbol   (symbol),
    .spinning (spinning),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0:       return 32'(pos);
      1:       return 32'(symbol);
      2:       return 32'(spinning);
      3:       return 32'(busy);
      default: return 32'(done);
    endcase
  endfunction

  function automatic logic [31:0] p3(input int a, input int b, input int c);
    return (32'(c) << 10) | (32'(b) << 5) | 32'(a);
  endfunction

  function automatic logic [31:0] s3(input int a, input int b, input int c);
    return (32'(c) << 6) | (32'(b) << 3) | 32'(a);
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, probe(e.sel), e.val);
    end
  endtask

  task automatic step(input logic r, input logic t,
                      input logic s, input logic p);
    rst = r; tick = t; start = s; stop = p;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef REEL_NUDGE_EN
    nudge = 1'b0; nudge_sel = 2'd0;
`endif
    step(1, 0, 0, 0);
    push("rst_pos", 0, p3(1, 1, 1));
    push("rst_sym", 1, s3(1, 1, 1));
    push("rst_busy", 3, 0);
    push("rst_spin", 2, 0);
    push("rst_done", 4, 0);
    drain();

    for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
    push("idle_pos", 0, p3(1, 1, 1));
    push("idle_sym", 1, s3(1, 1, 1));
    push("idle_busy", 3, 0);
    drain();

`ifdef REEL_NUDGE_EN
    for (int k = 0; k < 15; k++) begin
      nudge = 1'b1; nudge_sel = 2'd1;
      step(0, 0, 0, 0);
    end
    nudge = 1'b0;
    push("nudge_31", 0, p3(1, 31, 1));
    drain();
    nudge = 1'b1; nudge_sel = 2'd1;
    step(0, 0, 0, 0);
    nudge = 1'b1; nudge_sel = 2'd3;
    step(0, 0, 0, 0);
    nudge = 1'b0;
    push("nudge_wrap", 0, p3(1, 1, 1));
    drain();
    step(0, 0, 1, 0);
    nudge = 1'b1; nudge_sel = 2'd1;
    step(0, 0, 0, 0);
    nudge = 1'b0;
    push("nudge_spin", 0, p3(1, 1, 1));
    drain();
    step(1, 0, 0, 0);
`endif

    step(0, 0, 1, 1);
    push("start_busy", 3, 1);
    push("start_spin", 2, 3'b111);
    push("start_pos", 0, p3(1, 1, 1));
    drain();

    for (int k = 0; k < 30; k++) step(0, 1, 0, 0);
    push("spin31_pos", 0, p3(31, 31, 31));
    push("spin31_sym", 1, s3(7, 7, 7));
    push("spin31_spin", 2, 3'b111);
    push("spin31_busy", 3, 1);
    drain();

    step(0, 1, 0, 0);
    push("wrap0_pos", 0, p3(0, 0, 0));
    push("wrap0_sym", 1, s3(0, 0, 0));
    drain();
    step(0, 1, 0, 0);
    push("wrap1_pos", 0, p3(1, 1, 1));
    drain();

    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    push("at4_pos", 0, p3(4, 4, 4));
    drain();
    step(0, 0, 0, 1);
    push("stop_spin", 2, 3'b111);
    push("stop_busy", 3, 1);
    drain();
    step(0, 1, 0, 0);
    push("even_adv_pos", 0, p3(5, 5, 5));
    push("even_adv_spin", 2, 3'b111);
    drain();
    step(0, 1, 0, 0);
    push("r0_halt_pos", 0, p3(5, 6, 6));
    push("r0_halt_spin", 2, 3'b110);
    push("r0_halt_sym", 1, s3(3, 0, 0));
    drain();

    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0, 0);
      push("gap1_spin", 2, (k < 10) ? 3'b110 : 3'b100);
      push("gap1_done", 4, 0);
      drain();
    end
    push("r1_halt_pos", 0, p3(5, 15, 16));
    drain();

    for (int k = 1; k <= 10; k++) begin
      step(0, 1, 0, 0);
      push("gap2_spin", 2, (k < 10) ? 3'b100 : 3'b000);
      push("gap2_done", 4, (k < 10) ? 0 : 1);
      push("gap2_busy", 3, (k < 10) ? 1 : 0);
      drain();
    end
    push("final_pos", 0, p3(5, 15, 25));
    push("final_sym", 1, s3(3, 6, 2));
    drain();
    step(0, 1, 0, 0);
    push("done_width", 4, 0);
    push("idle_hold", 0, p3(5, 15, 25));
    drain();

    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    push("at7_pos", 0, p3(7, 17, 27));
    drain();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    push("odd_halt_pos", 0, p3(7, 18, 28));
    push("odd_halt_sym", 1, s3(4, 0, 0));
    push("odd_halt_spin", 2, 3'b110);
    drain();

    step(1, 1, 0, 0);
    push("mid_rst_pos", 0, p3(1, 1, 1));
    push("mid_rst_spin", 2, 0);
    push("mid_rst_busy", 3, 0);
    push("mid_rst_done", 4, 0);
    drain();
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 0);
      push("post_rst_done", 4, 0);
      drain();
    end
    push("post_rst_pos", 0, p3(1, 1, 1));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
